// File: rtl/gs_ddram_bridge.sv
// General Sound memory back-end: byte-wide GS requests onto single-beat 64-bit DDR3
// accesses, with a one-line write-through read cache for sequential fetches.
module gs_ddram_bridge #(
   parameter logic [28:0] BASE_ADDR = 29'h0600_0000,
   parameter int unsigned AW        = 21
) (
   input  logic          DDRAM_CLK,
   input  logic          reset,
   input  logic          flush,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   input  logic          rd,
   input  logic          we,
   output logic          ready,
   input  logic          DDRAM_BUSY,
   output logic [7:0]    DDRAM_BURSTCNT,
   output logic [28:0]   DDRAM_ADDR,
   input  logic [63:0]   DDRAM_DOUT,
   input  logic          DDRAM_DOUT_READY,
   output logic          DDRAM_RD,
   output logic [63:0]   DDRAM_DIN,
   output logic [7:0]    DDRAM_BE,
   output logic          DDRAM_WE
);

   localparam int unsigned TW = AW - 3;

   typedef enum logic [1:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD} state_t;

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic          ready_q, ready_d;
   logic [7:0]    dout_q, dout_d;
   logic          rd_cmd_q, rd_cmd_d;
   logic          we_cmd_q, we_cmd_d;
   logic          valid_q, valid_d;
   logic          drain_q, drain_d;
   logic [63:0]   line_q, line_d;
   logic [TW-1:0] line_tag_q, line_tag_d;
   logic [TW-1:0] req_tag_q, req_tag_d;
   logic [2:0]    req_sel_q, req_sel_d;
   logic [28:0]   ddr_addr_q, ddr_addr_d;
   logic [63:0]   ddr_din_q, ddr_din_d;
   logic [7:0]    ddr_be_q, ddr_be_d;

   logic          strobe, req_edge, new_wr, new_rd, hit, accept_req, drain_rst;
   logic [TW-1:0] addr_tag;

   assign addr_tag   = addr[AW-1:3];
   assign strobe     = rd | we;
   assign accept_req = (state_q == IDLE) && ready_q;
   assign req_edge   = strobe & ~req_q;
   assign new_wr     = req_edge & we;
   assign new_rd     = req_edge & rd & ~we;
   assign hit        = valid_q && !flush && (line_tag_q == addr_tag);

   // A read command already accepted by DDR3 still owes one data beat after reset.
   assign drain_rst = ((state_q == RD_WAIT) && !DDRAM_DOUT_READY) ||
                      ((state_q == RD_CMD) && rd_cmd_q && !DDRAM_BUSY) ||
                      (drain_q && !DDRAM_DOUT_READY);

   always_ff @(posedge DDRAM_CLK) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_req) begin
               if (new_wr)                          state_d = WR_CMD;
               else if (new_rd && !hit && !drain_q) state_d = RD_CMD;
            end else if (!drain_q) begin
               // ready low while idle means a miss stalled behind a drain
               state_d = RD_CMD;
            end
         end
         RD_CMD:  if (!DDRAM_BUSY)       state_d = RD_WAIT;
         RD_WAIT: if (DDRAM_DOUT_READY)  state_d = IDLE;
         WR_CMD:  if (!DDRAM_BUSY)       state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   always_comb begin
      ready_d    = ready_q;
      dout_d     = dout_q;
      valid_d    = valid_q & ~flush;
      drain_d    = drain_q & ~DDRAM_DOUT_READY;
      line_d     = line_q;
      line_tag_d = line_tag_q;
      req_tag_d  = req_tag_q;
      req_sel_d  = req_sel_q;
      ddr_addr_d = ddr_addr_q;
      ddr_din_d  = ddr_din_q;
      ddr_be_d   = ddr_be_q;
      req_d      = accept_req ? strobe : (req_q & strobe);
      rd_cmd_d   = (state_d == RD_CMD);
      we_cmd_d   = (state_d == WR_CMD);

      case (state_q)
         IDLE: begin
            if (accept_req && new_wr) begin
               ready_d    = 1'b0;
               ddr_addr_d = BASE_ADDR + 29'(addr_tag);
               ddr_be_d   = 8'b1 << addr[2:0];
               ddr_din_d  = {8{din}};
               if (hit) line_d[{addr[2:0], 3'b000} +: 8] = din;
            end else if (accept_req && new_rd) begin
               if (hit) begin
                  dout_d = line_q[{addr[2:0], 3'b000} +: 8];
               end else begin
                  ready_d    = 1'b0;
                  ddr_addr_d = BASE_ADDR + 29'(addr_tag);
                  req_tag_d  = addr_tag;
                  req_sel_d  = addr[2:0];
               end
            end
         end
         RD_WAIT: begin
            if (DDRAM_DOUT_READY) begin
               line_d     = DDRAM_DOUT;
               line_tag_d = req_tag_q;
               valid_d    = 1'b1;
               dout_d     = DDRAM_DOUT[{req_sel_q, 3'b000} +: 8];
               ready_d    = 1'b1;
            end
         end
         WR_CMD: if (!DDRAM_BUSY) ready_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge DDRAM_CLK) begin
      if (reset) begin
         ready_q  <= 1'b1;
         dout_q   <= 8'h00;
         rd_cmd_q <= 1'b0;
         we_cmd_q <= 1'b0;
         valid_q  <= 1'b0;
         req_q    <= strobe;
         drain_q  <= drain_rst;
      end else begin
         ready_q  <= ready_d;
         dout_q   <= dout_d;
         rd_cmd_q <= rd_cmd_d;
         we_cmd_q <= we_cmd_d;
         valid_q  <= valid_d;
         req_q    <= req_d;
         drain_q  <= drain_d;
      end
   end

   // Line storage and command payload carry no reset; valid_q and the strobes qualify them.
   always_ff @(posedge DDRAM_CLK) begin
      line_q     <= line_d;
      line_tag_q <= line_tag_d;
      req_tag_q  <= req_tag_d;
      req_sel_q  <= req_sel_d;
      ddr_addr_q <= ddr_addr_d;
      ddr_din_q  <= ddr_din_d;
      ddr_be_q   <= ddr_be_d;
   end

   assign ready          = ready_q;
   assign dout           = dout_q;
   assign DDRAM_BURSTCNT = 8'd1;
   assign DDRAM_ADDR     = ddr_addr_q;
   assign DDRAM_DIN      = ddr_din_q;
   assign DDRAM_BE       = ddr_be_q;
   assign DDRAM_RD       = rd_cmd_q;
   assign DDRAM_WE       = we_cmd_q;

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Directed bench for gs_ddram_bridge: miss/hit reads, write-through, flush,
// address wrap and reset while a read beat is still outstanding.
module tb_gs_ddram_bridge;

   logic        clk = 1'b0;
   logic        reset, flush, rd, we, ready;
   logic [20:0] addr;
   logic [7:0]  din, dout;
   logic        DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_RD, DDRAM_WE;
   logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
   logic [28:0] DDRAM_ADDR;
   logic [63:0] DDRAM_DOUT, DDRAM_DIN;

   int checks = 0;
   int errors = 0;

   gs_ddram_bridge dut (
      .DDRAM_CLK        (clk),
      .reset            (reset),
      .flush            (flush),
      .addr             (addr),
      .din              (din),
      .dout             (dout),
      .rd               (rd),
      .we               (we),
      .ready            (ready),
      .DDRAM_BUSY       (DDRAM_BUSY),
      .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
      .DDRAM_ADDR       (DDRAM_ADDR),
      .DDRAM_DOUT       (DDRAM_DOUT),
      .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
      .DDRAM_RD         (DDRAM_RD),
      .DDRAM_DIN        (DDRAM_DIN),
      .DDRAM_BE         (DDRAM_BE),
      .DDRAM_WE         (DDRAM_WE)
   );

   always #5 clk = ~clk;

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      rd    = 1'b1;
      sample();
      checks++;
      if ({ready, dout, DDRAM_RD, DDRAM_WE, DDRAM_BURSTCNT} !== {1'b1, 8'h00, 1'b0, 1'b0, 8'd1}) begin
         errors++;
         $display("FAIL reset_state: got rdy=%b dout=%h rd=%b we=%b bc=%h, expected 1 00 0 0 01",
                  ready, dout, DDRAM_RD, DDRAM_WE, DDRAM_BURSTCNT);
      end
      @(negedge clk);
      reset = 1'b0;
      sample();
      sample();
      checks++;
      if ({DDRAM_RD, ready} !== 2'b01) begin
         errors++;
         $display("FAIL held_strobe_at_release: got rd=%b rdy=%b, expected 0 1", DDRAM_RD, ready);
      end
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic test_read_miss();
      @(negedge clk);
      addr = 21'h000005;
      rd   = 1'b1;
      sample();
      checks++;
      if ({DDRAM_RD, ready, DDRAM_ADDR} !== {1'b1, 1'b0, 29'h0600_0000}) begin
         errors++;
         $display("FAIL miss_cmd: got rd=%b rdy=%b addr=%h, expected 1 0 06000000",
                  DDRAM_RD, ready, DDRAM_ADDR);
      end
      sample();
      checks++;
      if ({DDRAM_RD, ready} !== 2'b00) begin
         errors++;
         $display("FAIL miss_accept: got rd=%b rdy=%b, expected 0 0", DDRAM_RD, ready);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT       = 64'h8877_6655_4433_2211;
      sample();
      checks++;
      if ({ready, dout} !== {1'b1, 8'h66}) begin
         errors++;
         $display("FAIL miss_data: got rdy=%b dout=%h, expected 1 66", ready, dout);
      end
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b0;
      rd               = 1'b0;
   endtask

   task automatic test_read_hit();
      @(negedge clk);
      addr = 21'h000007;
      rd   = 1'b1;
      sample();
      checks++;
      if ({dout, ready, DDRAM_RD} !== {8'h88, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL hit_data: got dout=%h rdy=%b rd=%b, expected 88 1 0", dout, ready, DDRAM_RD);
      end
      @(negedge clk);
      rd = 1'b0;
      sample();
      checks++;
      if ({ready, DDRAM_RD} !== 2'b10) begin
         errors++;
         $display("FAIL hit_quiet: got rdy=%b rd=%b, expected 1 0", ready, DDRAM_RD);
      end
   endtask

   task automatic test_write_through();
      int wcnt;
      @(negedge clk);
      addr       = 21'h000003;
      din        = 8'hAB;
      we         = 1'b1;
      DDRAM_BUSY = 1'b1;
      sample();
      checks++;
      if ({DDRAM_WE, ready, DDRAM_BE, DDRAM_DIN} !== {1'b1, 1'b0, 8'h08, 64'hABAB_ABAB_ABAB_ABAB}) begin
         errors++;
         $display("FAIL wr_cmd: got we=%b rdy=%b be=%h din=%h, expected 1 0 08 abababababababab",
                  DDRAM_WE, ready, DDRAM_BE, DDRAM_DIN);
      end
      wcnt = DDRAM_WE ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
         sample();
         if (DDRAM_WE) wcnt++;
      end
      @(negedge clk);
      DDRAM_BUSY = 1'b0;
      sample();
      checks++;
      if ({DDRAM_WE, ready} !== 2'b01) begin
         errors++;
         $display("FAIL wr_done: got we=%b rdy=%b, expected 0 1", DDRAM_WE, ready);
      end
      checks++;
      if (wcnt !== 4) begin
         errors++;
         $display("FAIL wr_we_cycles: got %0d expected 4", wcnt);
      end
      @(negedge clk);
      we   = 1'b0;
      @(negedge clk);
      addr = 21'h000003;
      rd   = 1'b1;
      sample();
      checks++;
      if ({dout, ready, DDRAM_RD} !== {8'hAB, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL wr_through_hit: got dout=%h rdy=%b rd=%b, expected ab 1 0", dout, ready, DDRAM_RD);
      end
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic test_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      addr  = 21'h000000;
      rd    = 1'b1;
      sample();
      checks++;
      if ({DDRAM_RD, ready, DDRAM_ADDR} !== {1'b1, 1'b0, 29'h0600_0000}) begin
         errors++;
         $display("FAIL flush_miss: got rd=%b rdy=%b addr=%h, expected 1 0 06000000",
                  DDRAM_RD, ready, DDRAM_ADDR);
      end
      sample();
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT       = 64'h0102_0304_0506_0708;
      sample();
      checks++;
      if ({ready, dout} !== {1'b1, 8'h08}) begin
         errors++;
         $display("FAIL flush_refill: got rdy=%b dout=%h, expected 1 08", ready, dout);
      end
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b0;
      rd               = 1'b0;
   endtask

   task automatic test_addr_top();
      @(negedge clk);
      addr = 21'h1FFFF8;
      rd   = 1'b1;
      sample();
      checks++;
      if ({DDRAM_RD, DDRAM_ADDR} !== {1'b1, 29'h0603_FFFF}) begin
         errors++;
         $display("FAIL top_addr: got rd=%b addr=%h, expected 1 0603ffff", DDRAM_RD, DDRAM_ADDR);
      end
      sample();
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT       = 64'h0000_0000_0000_005A;
      sample();
      checks++;
      if ({ready, dout} !== {1'b1, 8'h5A}) begin
         errors++;
         $display("FAIL top_data: got rdy=%b dout=%h, expected 1 5a", ready, dout);
      end
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b0;
      rd               = 1'b0;
   endtask

   task automatic test_reset_drain();
      @(negedge clk);
      addr = 21'h000010;
      rd   = 1'b1;
      sample();
      sample();
      @(negedge clk);
      reset = 1'b1;
      rd    = 1'b0;
      sample();
      checks++;
      if ({ready, dout, DDRAM_RD} !== {1'b1, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL drain_reset: got rdy=%b dout=%h rd=%b, expected 1 00 0", ready, dout, DDRAM_RD);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT       = 64'hFFFF_FFFF_FFFF_FFFF;
      sample();
      checks++;
      if ({ready, dout} !== {1'b1, 8'h00}) begin
         errors++;
         $display("FAIL drain_discard: got rdy=%b dout=%h, expected 1 00", ready, dout);
      end
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b0;
      addr             = 21'h000010;
      rd               = 1'b1;
      sample();
      checks++;
      if ({DDRAM_RD, ready, DDRAM_ADDR} !== {1'b1, 1'b0, 29'h0600_0002}) begin
         errors++;
         $display("FAIL drain_fresh_cmd: got rd=%b rdy=%b addr=%h, expected 1 0 06000002",
                  DDRAM_RD, ready, DDRAM_ADDR);
      end
      sample();
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT       = 64'h1122_3344_5566_7788;
      sample();
      checks++;
      if ({ready, dout} !== {1'b1, 8'h88}) begin
         errors++;
         $display("FAIL drain_fresh_data: got rdy=%b dout=%h, expected 1 88", ready, dout);
      end
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b0;
      rd               = 1'b0;
      @(negedge clk);
      addr = 21'h000017;
      rd   = 1'b1;
      sample();
      checks++;
      if ({dout, DDRAM_RD} !== {8'h11, 1'b0}) begin
         errors++;
         $display("FAIL drain_line_hit: got dout=%h rd=%b, expected 11 0", dout, DDRAM_RD);
      end
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic test_drain_stall();
      @(negedge clk);
      addr = 21'h000020;
      rd   = 1'b1;
      sample();
      sample();
      @(negedge clk);
      reset = 1'b1;
      rd    = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rd = 1'b1;
      sample();
      checks++;
      if ({DDRAM_RD, ready} !== 2'b00) begin
         errors++;
         $display("FAIL stall_hold: got rd=%b rdy=%b, expected 0 0", DDRAM_RD, ready);
      end
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT       = 64'hFFFF_FFFF_FFFF_FFFF;
      sample();
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b0;
      sample();
      checks++;
      if ({DDRAM_RD, ready, DDRAM_ADDR} !== {1'b1, 1'b0, 29'h0600_0004}) begin
         errors++;
         $display("FAIL stall_release: got rd=%b rdy=%b addr=%h, expected 1 0 06000004",
                  DDRAM_RD, ready, DDRAM_ADDR);
      end
      sample();
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT       = 64'h0000_0000_0000_00C3;
      sample();
      checks++;
      if ({ready, dout} !== {1'b1, 8'hC3}) begin
         errors++;
         $display("FAIL stall_data: got rdy=%b dout=%h, expected 1 c3", ready, dout);
      end
      @(negedge clk);
      DDRAM_DOUT_READY = 1'b0;
      rd               = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset            = 1'b1;
      flush            = 1'b0;
      rd               = 1'b0;
      we               = 1'b0;
      addr             = '0;
      din              = '0;
      DDRAM_BUSY       = 1'b0;
      DDRAM_DOUT_READY = 1'b0;
      DDRAM_DOUT       = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_through();
      test_flush();
      test_addr_top();
      test_reset_drain();
      test_drain_stall();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
